// File: rtl/rgb_batch_packer.sv
// rtl/rgb_batch_packer.sv - packs DE-qualified RGB pixels into tagged per-channel batches
//
// Purpose:
//   Collects BATCH_SIZE consecutive active pixels per colour channel. Each batch
//   is tagged with its start-of-frame, start-of-line, batch index and line index.
//   Batches are offered downstream through a one-deep valid/ready output slot.
//   A batch that completes while the slot is still occupied is dropped, and the
//   sticky overflow flag is raised.
//
// Optional feature (macro RGB_BATCH_PACKER_STATS_EN):
//   Adds O_drop_count, a saturating count of dropped batches.
//   Adds O_frame_count, a wrapping count of VS edges.
//
// Ports:
//   I_rgb_clk                        pixel clock (sole clock)
//   I_rst_n                          asynchronous active-low reset
//   I_rgb_vs / I_rgb_hs / I_rgb_de   video timing (hs is informational only)
//   I_rgb_r / I_rgb_g / I_rgb_b      8-bit pixel colour
//   O_batch_r / O_batch_g / O_batch_b  packed batch, pixel k in bits [8k+7:8k]
//   O_batch_valid / I_batch_ready    output handshake
//   O_batch_sof / O_batch_sol        first batch of frame / of line
//   O_batch_idx / O_line_idx         batch index in line / line index in frame
//   O_overflow                       sticky: a completed batch was dropped
//   O_drop_count / O_frame_count     statistics (macro only)

module rgb_batch_packer #(
  parameter int BATCH_SIZE     = 8,
  parameter int H_ACTIVE       = 128,
  parameter int V_ACTIVE       = 32,
  parameter int VS_ACTIVE_HIGH = 1,
  localparam int IDX_W  = (H_ACTIVE / BATCH_SIZE > 1) ? $clog2(H_ACTIVE / BATCH_SIZE) : 1,
  localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1,
  localparam int DATA_W = 8 * BATCH_SIZE
) (
  input  logic              I_rgb_clk,
  input  logic              I_rst_n,
  input  logic              I_rgb_vs,
  input  logic              I_rgb_hs,
  input  logic              I_rgb_de,
  input  logic [7:0]        I_rgb_r,
  input  logic [7:0]        I_rgb_g,
  input  logic [7:0]        I_rgb_b,
  output logic [DATA_W-1:0] O_batch_r,
  output logic [DATA_W-1:0] O_batch_g,
  output logic [DATA_W-1:0] O_batch_b,
  output logic              O_batch_valid,
  input  logic              I_batch_ready,
  output logic              O_batch_sof,
  output logic              O_batch_sol,
  output logic [IDX_W-1:0]  O_batch_idx,
  output logic [LINE_W-1:0] O_line_idx,
  output logic              O_overflow
`ifdef RGB_BATCH_PACKER_STATS_EN
  ,
  output logic [15:0]       O_drop_count,
  output logic [15:0]       O_frame_count
`endif
);

  localparam int FILL_W = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;

  typedef enum logic {WAIT_VS, ACTIVE} frame_state_t;
  typedef enum logic {EMPTY, FULL} out_state_t;

  frame_state_t frame_state, frame_next;
  out_state_t   out_state, out_next;

  logic              vs_q;
  logic              de_q;
  logic              vs_edge;
  logic              de_rise;
  logic              de_fall;
  logic              line_end;
  logic              pix_en;
  logic              complete;
  logic              load;
  logic              drop;

  logic [FILL_W-1:0] fill_cnt;
  logic [FILL_W-1:0] fill_idx;
  logic [IDX_W-1:0]  batch_cnt;
  logic [IDX_W-1:0]  cur_batch_idx;
  logic [LINE_W-1:0] line_cnt;
  logic [LINE_W-1:0] cur_line;
  logic              sof_pending;
  logic              sol_pending;
  logic              tag_sof;
  logic              tag_sol;

  logic [DATA_W-1:0] fill_r, fill_g, fill_b;
  logic [DATA_W-1:0] batch_r, batch_g, batch_b;

  // Line boundaries come from DE alone.
  logic unused_hs;
  assign unused_hs = I_rgb_hs;

  // Edge detection against the registered syncs.
  assign vs_edge  = (VS_ACTIVE_HIGH != 0) ? (I_rgb_vs & ~vs_q) : (~I_rgb_vs & vs_q);
  assign de_rise  = I_rgb_de & ~de_q;
  assign de_fall  = ~I_rgb_de & de_q;
  assign line_end = de_fall & (frame_state == ACTIVE);

  // A VS edge takes effect before the pixel of the same cycle. That pixel is
  // therefore pixel 0 of the new frame, including on the WAIT_VS -> ACTIVE step.
  assign pix_en        = I_rgb_de & ((frame_state == ACTIVE) | vs_edge);
  assign fill_idx      = vs_edge ? '0 : fill_cnt;
  assign cur_batch_idx = vs_edge ? '0 : batch_cnt;
  assign cur_line      = vs_edge ? '0 : line_cnt;
  assign complete      = pix_en & (fill_idx == FILL_W'(BATCH_SIZE - 1));
  assign tag_sof       = sof_pending | vs_edge;
  assign tag_sol       = sol_pending | de_rise;

  assign load = complete & ((out_state == EMPTY) | I_batch_ready);
  assign drop = complete & (out_state == FULL) & ~I_batch_ready;

  assign O_batch_valid = (out_state == FULL);

  // The final pixel goes straight from the inputs into the output register.
  // Only slots 0..BATCH_SIZE-2 ever come from the fill registers.
  always_comb begin
    batch_r = fill_r;
    batch_g = fill_g;
    batch_b = fill_b;
    batch_r[8*(BATCH_SIZE-1) +: 8] = I_rgb_r;
    batch_g[8*(BATCH_SIZE-1) +: 8] = I_rgb_g;
    batch_b[8*(BATCH_SIZE-1) +: 8] = I_rgb_b;
  end

  // Frame FSM
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) frame_state <= WAIT_VS;
    else          frame_state <= frame_next;
  end

  always_comb begin
    frame_next = frame_state;
    case (frame_state)
      WAIT_VS: if (vs_edge) frame_next = ACTIVE;
      ACTIVE:  frame_next = ACTIVE;
      default: frame_next = WAIT_VS;
    endcase
  end

  // Output FSM
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) out_state <= EMPTY;
    else          out_state <= out_next;
  end

  always_comb begin
    out_next = out_state;
    case (out_state)
      EMPTY:   if (complete) out_next = FULL;
      FULL:    if (I_batch_ready && !complete) out_next = EMPTY;
      default: out_next = EMPTY;
    endcase
  end

  // Sync history
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_q <= (VS_ACTIVE_HIGH == 0);
      de_q <= 1'b0;
    end else begin
      vs_q <= I_rgb_vs;
      de_q <= I_rgb_de;
    end
  end

  // Position counters and tag flags
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      fill_cnt    <= '0;
      batch_cnt   <= '0;
      line_cnt    <= '0;
      sof_pending <= 1'b0;
      sol_pending <= 1'b0;
    end else begin
      // fill_cnt wraps to 0 on completion because BATCH_SIZE is a power of two.
      if (pix_en)                   fill_cnt <= fill_idx + 1'b1;
      else if (vs_edge || line_end) fill_cnt <= '0;

      // Dropped batches still advance the index.
      if (complete)                 batch_cnt <= cur_batch_idx + 1'b1;
      else if (vs_edge || line_end) batch_cnt <= '0;

      if (vs_edge)       line_cnt <= '0;
      else if (line_end) line_cnt <= (line_cnt == LINE_W'(V_ACTIVE - 1)) ? '0 : line_cnt + 1'b1;

      if (vs_edge)       sof_pending <= 1'b1;
      else if (complete) sof_pending <= 1'b0;

      if (complete)     sol_pending <= 1'b0;
      else if (de_rise) sol_pending <= 1'b1;
    end
  end

  // Fill registers
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      fill_r <= '0;
      fill_g <= '0;
      fill_b <= '0;
    end else if (pix_en) begin
      fill_r[8*int'(fill_idx) +: 8] <= I_rgb_r;
      fill_g[8*int'(fill_idx) +: 8] <= I_rgb_g;
      fill_b[8*int'(fill_idx) +: 8] <= I_rgb_b;
    end
  end

  // Output slot
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_batch_r   <= '0;
      O_batch_g   <= '0;
      O_batch_b   <= '0;
      O_batch_sof <= 1'b0;
      O_batch_sol <= 1'b0;
      O_batch_idx <= '0;
      O_line_idx  <= '0;
      O_overflow  <= 1'b0;
    end else begin
      if (load) begin
        O_batch_r   <= batch_r;
        O_batch_g   <= batch_g;
        O_batch_b   <= batch_b;
        O_batch_sof <= tag_sof;
        O_batch_sol <= tag_sol;
        O_batch_idx <= cur_batch_idx;
        O_line_idx  <= cur_line;
      end
      if (drop) O_overflow <= 1'b1;
    end
  end

`ifdef RGB_BATCH_PACKER_STATS_EN
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_drop_count  <= '0;
      O_frame_count <= '0;
    end else begin
      if (drop && (O_drop_count != 16'hFFFF)) O_drop_count <= O_drop_count + 16'd1;
      if (vs_edge) O_frame_count <= O_frame_count + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_rgb_batch_packer.sv
// tb/tb_rgb_batch_packer.sv - scoreboard bench for rgb_batch_packer

module tb_rgb_batch_packer;

  localparam int B  = 8;
  localparam int H  = 128;
  localparam int V  = 32;
  localparam int NB = H / B;
  localparam int IW = $clog2(NB);
  localparam int LW = $clog2(V);
  localparam int BW = 8 * B;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vs, hs, de;
  logic [7:0]    pr, pg, pb;
  logic [BW-1:0] o_r, o_g, o_b;
  logic          o_valid, ready, o_sof, o_sol, o_ovf;
  logic [IW-1:0] o_idx;
  logic [LW-1:0] o_line;
`ifdef RGB_BATCH_PACKER_STATS_EN
  logic [15:0]   o_drops, o_frames;
`endif

  always #5 clk = ~clk;

  rgb_batch_packer #(.BATCH_SIZE(B), .H_ACTIVE(H), .V_ACTIVE(V), .VS_ACTIVE_HIGH(1)) dut (
    .I_rgb_clk    (clk),
    .I_rst_n      (rst_n),
    .I_rgb_vs     (vs),
    .I_rgb_hs     (hs),
    .I_rgb_de     (de),
    .I_rgb_r      (pr),
    .I_rgb_g      (pg),
    .I_rgb_b      (pb),
    .O_batch_r    (o_r),
    .O_batch_g    (o_g),
    .O_batch_b    (o_b),
    .O_batch_valid(o_valid),
    .I_batch_ready(ready),
    .O_batch_sof  (o_sof),
    .O_batch_sol  (o_sol),
    .O_batch_idx  (o_idx),
    .O_line_idx   (o_line),
    .O_overflow   (o_ovf)
`ifdef RGB_BATCH_PACKER_STATS_EN
    ,
    .O_drop_count (o_drops),
    .O_frame_count(o_frames)
`endif
  );

  typedef struct {
    logic [BW-1:0] r, g, b;
    logic          sof, sol;
    int            idx, line;
  } batch_t;

  batch_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: pixels are collected in queues and a batch forms whenever
  // B pixels have accumulated. The output slot is tracked as a single full flag.
  logic       m_active, m_pvs, m_pde, m_sof, m_sol, m_full, m_ovf;
  int         m_bcnt, m_line, m_drops, m_frames;
  logic [7:0] m_pr[$], m_pg[$], m_pb[$];

  task automatic model_reset();
    m_active = 0; m_pvs = 0; m_pde = 0; m_sof = 0; m_sol = 0; m_full = 0; m_ovf = 0;
    m_bcnt = 0; m_line = 0; m_drops = 0; m_frames = 0;
    m_pr.delete(); m_pg.delete(); m_pb.delete();
    sb.delete();
  endtask

  task automatic model_step(input logic v, input logic d, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic rdy);
    logic   edge_vs;
    logic   done;
    batch_t t;
    edge_vs = v && !m_pvs;
    if (edge_vs) begin
      m_active = 1; m_bcnt = 0; m_line = 0; m_sof = 1; m_frames++;
      m_pr.delete(); m_pg.delete(); m_pb.delete();
    end else if (m_active && m_pde && !d) begin
      m_bcnt = 0; m_line = (m_line + 1) % V;
      m_pr.delete(); m_pg.delete(); m_pb.delete();
    end
    if (d && !m_pde) m_sol = 1;
    done = 0;
    if (m_active && d) begin
      m_pr.push_back(r); m_pg.push_back(g); m_pb.push_back(b);
      if (m_pr.size() == B) begin
        done = 1;
        t.r = '0; t.g = '0; t.b = '0;
        for (int k = 0; k < B; k++) begin
          t.r[8*k +: 8] = m_pr[k];
          t.g[8*k +: 8] = m_pg[k];
          t.b[8*k +: 8] = m_pb[k];
        end
        t.sof = m_sof; t.sol = m_sol; t.idx = m_bcnt; t.line = m_line;
        m_bcnt = (m_bcnt + 1) % NB; m_sof = 0; m_sol = 0;
        m_pr.delete(); m_pg.delete(); m_pb.delete();
        if (!m_full || rdy) begin
          sb.push_back(t);
          m_full = 1;
        end else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
    if (!done && m_full && rdy) m_full = 0;
    m_pvs = v; m_pde = d;
  endtask

  // Monitor
  logic          hold_prev = 0;
  logic [BW-1:0] held_r, held_g, held_b;
  logic [IW-1:0] held_idx;
  batch_t        mon_t;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", o_valid, m_full);
      chk("overflow", o_ovf, m_ovf);
      if (hold_prev) begin
        chk("hold_r", o_r, held_r);
        chk("hold_g", o_g, held_g);
        chk("hold_b", o_b, held_b);
        chk("hold_idx", o_idx, held_idx);
      end
      if (o_valid && ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty actual=unexpected batch idx %0d expected=no batch", o_idx);
        end else begin
          mon_t = sb.pop_front();
          chk("batch_r", o_r, mon_t.r);
          chk("batch_g", o_g, mon_t.g);
          chk("batch_b", o_b, mon_t.b);
          chk("batch_sof", o_sof, mon_t.sof);
          chk("batch_sol", o_sol, mon_t.sol);
          chk("batch_idx", o_idx, mon_t.idx);
          chk("batch_line", o_line, mon_t.line);
        end
      end
      hold_prev = o_valid && !ready;
      held_r = o_r; held_g = o_g; held_b = o_b; held_idx = o_idx;
    end else begin
      hold_prev = 0;
    end
  end

  // Stimulus
  task automatic cyc(input logic v, input logic d, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b, input logic rdy);
    vs = v; de = d; hs = ~d; pr = r; pg = g; pb = b; ready = rdy;
    @(posedge clk);
    model_step(v, d, r, g, b, rdy);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 8'h00, 8'h00, rdy);
  endtask

  task automatic vs_pulse(input logic rdy);
    cyc(1, 0, 8'h00, 8'h00, 8'h00, rdy);
    cyc(0, 0, 8'h00, 8'h00, 8'h00, rdy);
  endtask

  // mode 0: ready high, 1: ready low, 2: random, 3: ready only on completion cycles
  task automatic pix_line(input int n, input int mode);
    logic rdy;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       rdy = 1;
        1:       rdy = 0;
        2:       rdy = 1'($urandom);
        default: rdy = ((i % B) == B - 1);
      endcase
      cyc(0, 1, 8'($urandom), 8'($urandom), 8'($urandom), rdy);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_ovf"}, o_ovf, 0);
    chk({tag, "_r"}, o_r, 0);
    chk({tag, "_g"}, o_g, 0);
    chk({tag, "_b"}, o_b, 0);
    chk({tag, "_sof"}, o_sof, 0);
    chk({tag, "_sol"}, o_sol, 0);
    chk({tag, "_idx"}, o_idx, 0);
    chk({tag, "_line"}, o_line, 0);
`ifdef RGB_BATCH_PACKER_STATS_EN
    chk({tag, "_drops"}, o_drops, 0);
    chk({tag, "_frames"}, o_frames, 0);
`endif
  endtask

  initial begin
    rst_n = 0; vs = 0; hs = 1; de = 0; pr = 0; pg = 0; pb = 0; ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1;

    // 1: pixels before VS are ignored; the first batch after VS is tagged sof/sol
    pix_line(8, 0);
    idle(3, 1);
    vs_pulse(1);
    idle(2, 1);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 8'(i), 8'h00, 8'h00, 1);
    chk("t1_valid", o_valid, 1);
    chk("t1_r", o_r, 64'h0807060504030201);
    chk("t1_sof", o_sof, 1);
    chk("t1_sol", o_sol, 1);
    chk("t1_idx", o_idx, 0);
    chk("t1_line", o_line, 0);
    idle(4, 1);

    // 2: full lines with ready held high
    pix_line(H, 0);
    idle(4, 1);
    pix_line(H, 0);
    idle(4, 1);

    // 4: accept coincides with completion
    pix_line(H, 3);
    idle(4, 1);
    chk("t4_no_overflow", o_ovf, 0);

    // 5: VS edge on the 6th pixel of a batch, with DE high in the same cycle
    pix_line(5, 0);
    cyc(1, 1, 8'hA0, 8'hB0, 8'hC0, 1);
    pix_line(7, 0);
    chk("t5_valid", o_valid, 1);
    chk("t5_sof", o_sof, 1);
    chk("t5_idx", o_idx, 0);
    chk("t5_line", o_line, 0);
    idle(4, 1);

    // 3: ready low for a whole line
    pix_line(H, 1);
    idle(2, 0);
    chk("t3_overflow", o_ovf, 1);
    chk("t3_valid", o_valid, 1);
    chk("t3_idx", o_idx, 0);
`ifdef RGB_BATCH_PACKER_STATS_EN
    chk("t3_drops", o_drops, 15);
`endif
    idle(3, 1);
    chk("t3_drained", o_valid, 0);

    // 6: asynchronous reset while a batch is held
    pix_line(8, 1);
    idle(1, 0);
    chk("t6_held", o_valid, 1);
    #1 rst_n = 0;
    #1 chk_all_zero("t6_reset");
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    pix_line(16, 0);
    idle(3, 1);
    vs_pulse(1);
    pix_line(H, 2);
    idle(3, 1);

    // Randomized frames, lines and ready patterns
    for (int f = 0; f < 2; f++) begin
      vs_pulse(1'($urandom));
      for (int l = 0; l < 4; l++) begin
        pix_line(($urandom % 3 == 0) ? int'($urandom_range(1, H)) : H, int'($urandom % 4));
        idle(3 + int'($urandom % 4), 1'($urandom));
      end
    end

    idle(20, 1);
    chk("sb_drain", sb.size(), 0);
`ifdef RGB_BATCH_PACKER_STATS_EN
    chk("frames", o_frames, m_frames);
    chk("drops", o_drops, m_drops);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
